spawn_scheduler: RTL and testbench
==================================

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 Parameter BASE_INTERVAL, default 8'd40: initial cycles between spawn attempts.
REQ-002 Parameter MIN_INTERVAL, default 8'd10: interval floor.
REQ-003 Parameter STEP, default 8'd4: interval reduction per difficulty step.
REQ-004 Parameter LFSR_SEED, default 8'hA5: non-zero LFSR reset value.
REQ-005 Parameter Y_SPAWN, default 4'd0: enemy spawn row.
REQ-006 Port clk  input  1: single clock; all logic on its rising edge.
REQ-007 Port rst  input  1: reset, synchronous, active-high.
REQ-008 Port enable  input  1: scheduler runs while high.
REQ-009 Port enemy_active  input  3: {enemy2_active, enemy1_active, enemy0_active} from game_design.
REQ-010 Port hit  input  1: one-cycle hit pulse from game_design.
REQ-011 Port enemy_spawn  output  1: one-cycle spawn request to game_design.
REQ-012 Port enemy_init_x  output  5: spawn column, 0..19.
REQ-013 Port enemy_init_y  output  4: spawn row.
REQ-014 Port level  output  4: difficulty level, saturating at 15.
REQ-015 Port interval  output  8: current spawn interval.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, SPAWN and SETTLE, with an 8-bit wait counter.
REQ-017 IDLE: counter held at 0; go to WAIT when enable=1.
REQ-018 WAIT: counter increments each cycle until count >= interval-1 (terminal); use >= so a mid-wait interval decrease cannot strand the counter.
REQ-019 At terminal count, if any enemy_active bit is 0, go to SPAWN; otherwise hold in WAIT at terminal count (blocked) and move to SPAWN on the first cycle a slot is free.
REQ-020 On the WAIT->SPAWN transition, enemy_init_x/enemy_init_y SHALL be latched; they SHALL stay stable through SPAWN and SETTLE.
REQ-021 SPAWN: enemy_spawn=1 for exactly this one cycle; next state SETTLE.
REQ-022 SETTLE: one cycle for enemy_active to update, enemy_spawn=0, counter cleared; next state WAIT.
REQ-023 enable=0 in any state SHALL force IDLE next cycle; an in-progress SPAWN cycle still completes its single pulse.
REQ-024 An 8-bit Fibonacci LFSR (taps x^8+x^6+x^5+x^4+1) SHALL advance every cycle out of reset, independent of FSM state.
REQ-025 Candidate column c = lfsr[4:0]; enemy_init_x = c-20 when c >= 20, else c; result is always within 0..19.
REQ-026 enemy_init_y SHALL equal Y_SPAWN.
REQ-027 A 3-bit hit counter SHALL increment on each hit pulse.
REQ-028 On the 8th hit (counter wrap 7->0), interval SHALL decrease by STEP, saturating at MIN_INTERVAL, and level SHALL increment, saturating at 15.
REQ-029 Hit handling SHALL be independent of FSM state and enable; a hit coincident with a spawn SHALL affect both.
REQ-030 enemy_spawn SHALL never assert while enemy_active == 3'b111 on that cycle's latch decision.

Reset
REQ-031 With rst=1: state IDLE, counter 0, enemy_spawn 0, enemy_init_x 0, enemy_init_y 0, level 0, interval BASE_INTERVAL, hit counter 0, LFSR LFSR_SEED.
REQ-032 Reset asserted mid-operation (including during SPAWN) SHALL take effect on the next edge and suppress any further pulse.

Structure
REQ-033 A shared package game_pkg SHALL hold GRID_W=20, GRID_H=15, X_W=5, Y_W=4 and the scheduler state enum.
REQ-034 The LFSR SHALL be a sub-module lfsr8 (clk, rst, seed parameter, 8-bit q); everything else stays in spawn_scheduler.

Verification
REQ-035 Reset: rst=1 for 3 cycles -> all outputs at reset values, interval=40, level=0.
REQ-036 BASE_INTERVAL=16, enable=1, enemy_active=000 -> first enemy_spawn pulse 17 cycles after enable (IDLE + 16 WAIT), then repeats every 18 cycles; pulse width exactly 1.
REQ-037 enemy_active=111 held for 50 cycles past terminal count -> no spawn; drop to 110 -> enemy_spawn on the next cycle's SPAWN state.
REQ-038 Free-run 1000 spawns -> every enemy_init_x in 0..19 and enemy_init_y=0; sequence matches a reference LFSR model from seed A5.
REQ-039 16 hit pulses with BASE 40, STEP 4 -> interval 32, level 2; 200 hits with MIN 10 -> interval 10, level 15.
REQ-040 rst pulsed during SPAWN and enable dropped during WAIT -> no additional pulse, and FSM in IDLE the following cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, the spawn scheduler state type and the column mapping helper.
package game_pkg;
    localparam int GRID_W = 20;
    localparam int GRID_H = 15;
    localparam int X_W    = 5;
    localparam int Y_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SPAWN  = 2'd2,
        SETTLE = 2'd3
    } sched_state_t;

    // Fold a 5-bit LFSR slice (0..31) onto the 0..GRID_W-1 column range.
    function automatic logic [X_W-1:0] spawn_column(input logic [7:0] lfsr);
        logic [X_W-1:0] c;
        c = lfsr[X_W-1:0];
        if (c >= X_W'(GRID_W))
            return c - X_W'(GRID_W);
        else
            return c;
    endfunction
endpackage

// File: rtl/spawn_scheduler_if.sv
// Handshake between game_design (master) and the spawn scheduler (slave).
interface spawn_scheduler_if;
    import game_pkg::*;

    logic           enable;
    logic [2:0]     enemy_active;
    logic           hit;
    logic           enemy_spawn;
    logic [X_W-1:0] enemy_init_x;
    logic [Y_W-1:0] enemy_init_y;
    logic [3:0]     level;
    logic [7:0]     interval;

    modport master (
        output enable, enemy_active, hit,
        input  enemy_spawn, enemy_init_x, enemy_init_y, level, interval
    );

    modport slave (
        input  enable, enemy_active, hit,
        output enemy_spawn, enemy_init_x, enemy_init_y, level, interval
    );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);
    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
    assign q    = r_q;

    // Shift left every cycle, feeding the tap parity into bit 0.
    always_ff @(posedge clk) begin
        if (rst) r_q <= SEED;
        else     r_q <= {r_q[6:0], w_fb};
    end
endmodule

// File: rtl/spawn_scheduler.sv
// Enemy spawn scheduler: waits an interval, spawns into a free slot at a
// pseudo-random column, and shortens the interval every eighth hit.
module spawn_scheduler
    import game_pkg::*;
#(
    parameter logic [7:0] BASE_INTERVAL = 8'd40,
    parameter logic [7:0] MIN_INTERVAL  = 8'd10,
    parameter logic [7:0] STEP          = 8'd4,
    parameter logic [7:0] LFSR_SEED     = 8'hA5,
    parameter logic [3:0] Y_SPAWN       = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    spawn_scheduler_if.slave   bus
);
    sched_state_t   r_state, w_state_nxt;
    logic [7:0]     r_count, w_count_nxt;
    logic           w_latch, w_spawn, w_terminal, w_slot_free;
    logic [7:0]     w_lfsr;
    logic [X_W-1:0] r_init_x;
    logic [Y_W-1:0] r_init_y;
    logic [2:0]     r_hit_cnt;
    logic [3:0]     r_level;
    logic [7:0]     r_interval;
    logic           w_step_hit;
    logic [8:0]     w_floor_plus_step;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    // >= rather than == so a shrinking interval never strands the counter past terminal.
    assign w_terminal  = (r_count >= (r_interval - 8'd1));
    assign w_slot_free = ~&bus.enemy_active;

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state, counter and spawn-pulse decode; enable low overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_latch     = 1'b0;
        w_spawn     = 1'b0;
        case (r_state)
            IDLE: begin
                w_count_nxt = 8'd0;
                if (bus.enable) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (!w_terminal) begin
                    w_count_nxt = r_count + 8'd1;
                end else if (w_slot_free) begin
                    w_state_nxt = SPAWN;
                    w_latch     = 1'b1;
                end
            end
            SPAWN: begin
                w_spawn     = 1'b1;
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                w_count_nxt = 8'd0;
                w_state_nxt = WAIT;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!bus.enable) begin
            w_state_nxt = IDLE;
            w_count_nxt = 8'd0;
            w_latch     = 1'b0;
        end
    end

    // Spawn coordinates captured on the WAIT->SPAWN decision, held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_x <= '0;
            r_init_y <= '0;
        end else if (w_latch) begin
            r_init_x <= spawn_column(w_lfsr);
            r_init_y <= Y_SPAWN;
        end
    end

    assign w_step_hit        = bus.hit && (r_hit_cnt == 3'd7);
    assign w_floor_plus_step = {1'b0, MIN_INTERVAL} + {1'b0, STEP};

    // Difficulty ramp: count hits regardless of FSM state; every eighth one tightens the interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= 3'd0;
            r_level    <= 4'd0;
            r_interval <= BASE_INTERVAL;
        end else if (bus.hit) begin
            r_hit_cnt <= r_hit_cnt + 3'd1;
            if (w_step_hit) begin
                if (r_level != 4'd15) r_level <= r_level + 4'd1;
                if ({1'b0, r_interval} >= w_floor_plus_step)
                    r_interval <= r_interval - STEP;
                else
                    r_interval <= MIN_INTERVAL;
            end
        end
    end

    assign bus.enemy_spawn  = w_spawn;
    assign bus.enemy_init_x = r_init_x;
    assign bus.enemy_init_y = r_init_y;
    assign bus.level        = r_level;
    assign bus.interval     = r_interval;
endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: default-parameter instance for reset and
// difficulty ramp, BASE_INTERVAL=16 instance for timing, blocking and column sequence.
module tb_spawn_scheduler;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    spawn_scheduler_if bus_a ();
    spawn_scheduler_if bus_b ();

    spawn_scheduler u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    spawn_scheduler #(.BASE_INTERVAL(8'd16)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Reference LFSR; ref_prev holds the value seen during the cycle before the last edge.
    logic [7:0] ref_lfsr, ref_prev;
    always @(posedge clk) begin
        ref_prev <= ref_lfsr;
        if (rst) ref_lfsr <= 8'hA5;
        else     ref_lfsr <= {ref_lfsr[6:0], ^(ref_lfsr & 8'hB8)};
    end

    function automatic int exp_col(input logic [7:0] v);
        int c;
        c = int'(v) % 32;
        return (c >= 20) ? c - 20 : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_spawn_b(input string tag);
        int t;
        t = 0;
        do begin
            cyc(1);
            t++;
        end while (bus_b.enemy_spawn !== 1'b1 && t < 40);
        chk(tag, 32'(bus_b.enemy_spawn), 32'd1);
    endtask

    task automatic hit_a(input int n);
        repeat (n) begin
            bus_a.hit = 1'b1;
            cyc(1);
            bus_a.hit = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        int saw;
        bus_a.enable = 1'b0; bus_a.enemy_active = 3'b000; bus_a.hit = 1'b0;
        bus_b.enable = 1'b0; bus_b.enemy_active = 3'b000; bus_b.hit = 1'b0;

        // Reset held for three cycles
        cyc(3);
        chk("rst_spawn",    32'(bus_a.enemy_spawn),  32'd0);
        chk("rst_x",        32'(bus_a.enemy_init_x), 32'd0);
        chk("rst_y",        32'(bus_a.enemy_init_y), 32'd0);
        chk("rst_level",    32'(bus_a.level),        32'd0);
        chk("rst_interval", 32'(bus_a.interval),     32'd40);
        chk("rst_interval_b", 32'(bus_b.interval),   32'd16);
        chk("rst_state",    32'(u_dut_b.r_state),    32'(IDLE));

        // First pulse 17 edges after enable, then every 18
        rst = 1'b0;
        bus_b.enable = 1'b1;
        cyc(16);
        chk("first_pre",   32'(bus_b.enemy_spawn), 32'd0);
        cyc(1);
        chk("first_pulse", 32'(bus_b.enemy_spawn), 32'd1);
        chk("first_x",     32'(bus_b.enemy_init_x), 32'(exp_col(ref_prev)));
        cyc(1);
        chk("pulse_width", 32'(bus_b.enemy_spawn), 32'd0);
        cyc(16);
        chk("second_pre",  32'(bus_b.enemy_spawn), 32'd0);
        cyc(1);
        chk("second_pulse", 32'(bus_b.enemy_spawn), 32'd1);

        // All slots busy: no spawn for 50 cycles past terminal
        bus_b.enemy_active = 3'b111;
        saw = 0;
        repeat (67) begin
            cyc(1);
            if (bus_b.enemy_spawn) saw++;
        end
        chk("blocked_no_spawn", 32'(saw), 32'd0);
        bus_b.enemy_active = 3'b110;
        cyc(1);
        chk("unblocked_spawn", 32'(bus_b.enemy_spawn), 32'd1);
        chk("unblocked_x",     32'(bus_b.enemy_init_x), 32'(exp_col(ref_prev)));
        bus_b.enemy_active = 3'b000;

        // Column sequence over 1000 spawns
        for (int i = 0; i < 1000; i++) begin
            wait_spawn_b("run_spawn");
            chk("run_x",     32'(bus_b.enemy_init_x), 32'(exp_col(ref_prev)));
            chk("run_x_rng", 32'(bus_b.enemy_init_x < 5'd20), 32'd1);
            chk("run_y",     32'(bus_b.enemy_init_y), 32'd0);
        end

        // Hits spanning a spawn cycle still count
        bus_b.hit = 1'b1;
        cyc(8);
        bus_b.hit = 1'b0;
        chk("coinc_interval", 32'(bus_b.interval), 32'd12);
        chk("coinc_level",    32'(bus_b.level),    32'd1);

        // Difficulty ramp while disabled
        hit_a(7);
        chk("hit7_interval",  32'(bus_a.interval), 32'd40);
        hit_a(1);
        chk("hit8_interval",  32'(bus_a.interval), 32'd36);
        chk("hit8_level",     32'(bus_a.level),    32'd1);
        hit_a(8);
        chk("hit16_interval", 32'(bus_a.interval), 32'd32);
        chk("hit16_level",    32'(bus_a.level),    32'd2);
        hit_a(200);
        chk("hit216_interval", 32'(bus_a.interval), 32'd10);
        chk("hit216_level",    32'(bus_a.level),    32'd15);

        // Reset during SPAWN
        wait_spawn_b("pre_rst_spawn");
        rst = 1'b1;
        cyc(1);
        chk("rst_mid_spawn", 32'(bus_b.enemy_spawn), 32'd0);
        chk("rst_mid_state", 32'(u_dut_b.r_state),   32'(IDLE));
        chk("rst_mid_interval", 32'(bus_b.interval), 32'd16);
        cyc(1);
        chk("rst_hold_spawn", 32'(bus_b.enemy_spawn), 32'd0);
        rst = 1'b0;

        // Enable dropped mid-WAIT
        cyc(5);
        chk("wait_state", 32'(u_dut_b.r_state), 32'(WAIT));
        bus_b.enable = 1'b0;
        cyc(1);
        chk("disable_state", 32'(u_dut_b.r_state), 32'(IDLE));
        saw = 0;
        repeat (40) begin
            cyc(1);
            if (bus_b.enemy_spawn) saw++;
        end
        chk("disabled_no_spawn", 32'(saw), 32'd0);
        chk("disabled_idle",     32'(u_dut_b.r_state), 32'(IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
